max7219_receiver: RTL

- Responder end of the MAX7219 serial link: an emulated MAX7219 that receives SPI frames on `spi_clk`/`din`/`cs` and holds the MAX7219 register file.
- Used as an in-fabric display model and bench target behind `max7219_display`.
- Also drives a board-level display emulator from decoded register contents.
- Provides a daisy-chain `dout` so several receivers can be cascaded like real parts.

---
 rtl/max7219_pkg.sv | 27 ++
 rtl/max7219_receiver_if.sv | 12 +
 rtl/max7219_rx_sync.sv | 29 ++
 rtl/max7219_receiver.sv | 119 +++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 receiver, display model and sequencer:
// register addresses, frame width and the receiver state encoding.
package max7219_pkg;

  localparam int FRAME_W = 16;

  localparam logic [3:0] REG_NOP          = 4'h0;
  localparam logic [3:0] REG_DIGIT0       = 4'h1;
  localparam logic [3:0] REG_DIGIT1       = 4'h2;
  localparam logic [3:0] REG_DIGIT2       = 4'h3;
  localparam logic [3:0] REG_DIGIT3       = 4'h4;
  localparam logic [3:0] REG_DIGIT4       = 4'h5;
  localparam logic [3:0] REG_DIGIT5       = 4'h6;
  localparam logic [3:0] REG_DIGIT6       = 4'h7;
  localparam logic [3:0] REG_DIGIT7       = 4'h8;
  localparam logic [3:0] REG_DECODE_MODE  = 4'h9;
  localparam logic [3:0] REG_INTENSITY    = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
  localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/max7219_receiver_if.sv
// Serial link between a MAX7219 transmitter (master) and a receiver (slave).
// No handshake: the receiver samples din on spi_clk rising edges while cs is
// low; a frame closes on the rising edge of cs. dout is the daisy-chain output.
interface max7219_receiver_if;
  logic spi_clk;
  logic din;
  logic cs;
  logic dout;

  modport master (output spi_clk, output din, output cs, input dout);
  modport slave  (input spi_clk, input din, input cs, output dout);
endinterface

// File: rtl/max7219_rx_sync.sv
// Multi-flop synchroniser for one asynchronous input followed by a history
// flop that yields single-cycle rise/fall strobes in the clk domain.
module max7219_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/max7219_receiver.sv
// Emulated MAX7219: shifts in 16-bit frames from an asynchronous serial link,
// updates the register file on cs rising and forwards the frame on dout.
module max7219_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  max7219_receiver_if.slave        spi,
  output logic [63:0]              digits,
  output logic [7:0]               decode_mode,
  output logic [3:0]               intensity,
  output logic [2:0]               scan_limit,
  output logic                     normal_op,
  output logic                     display_test,
  output logic                     wr_valid,
  output logic [3:0]               wr_addr,
  output logic [7:0]               wr_data,
  output logic                     frame_err,
  output rx_state_t                dbg_state
);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] din_q;
  logic din_sync;

  max7219_rx_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .reset(reset), .async_in(spi.spi_clk), .rise(sck_rise), .fall(sck_fall)
  );

  max7219_rx_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset(reset), .async_in(spi.cs), .rise(cs_rise), .fall(cs_fall)
  );

  // din needs only its level, kept at the same latency as the strobes' source stage.
  always_ff @(posedge clk) begin
    if (reset) din_q <= '0;
    else       din_q <= {din_q[SYNC_STAGES-2:0], spi.din};
  end
  assign din_sync = din_q[SYNC_STAGES-1];

  rx_state_t          state_q;
  logic [FRAME_W-1:0] shift_q, shift_nxt;
  logic [4:0]         bit_cnt_q, cnt_nxt;
  logic [2:0]         digit_idx;

  // A rising spi_clk coinciding with cs_rise still lands in the frame, so the
  // close logic looks at the post-shift values.
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = bit_cnt_q;
    if (state_q == RX_SHIFT && sck_rise) begin
      shift_nxt = {shift_q[FRAME_W-2:0], din_sync};
      if (bit_cnt_q != 5'd31) cnt_nxt = bit_cnt_q + 5'd1;
    end
  end

  assign digit_idx = 3'(shift_nxt[11:8] - 4'd1);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      spi.dout     <= 1'b0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      normal_op    <= 1'b0;
      display_test <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_err    <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (cs_fall) begin
            state_q   <= RX_SHIFT;
            bit_cnt_q <= '0;
          end
        end
        RX_SHIFT: begin
          shift_q   <= shift_nxt;
          bit_cnt_q <= cnt_nxt;
          if (sck_fall) spi.dout <= shift_q[FRAME_W-1];
          if (cs_rise) begin
            state_q <= RX_IDLE;
            if (cnt_nxt >= 5'(FRAME_W)) begin
              wr_valid <= 1'b1;
              wr_addr  <= shift_nxt[11:8];
              wr_data  <= shift_nxt[7:0];
              case (shift_nxt[11:8])
                REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
                REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                  digits[{digit_idx, 3'b000} +: 8] <= shift_nxt[7:0];
                REG_DECODE_MODE:  decode_mode  <= shift_nxt[7:0];
                REG_INTENSITY:    intensity    <= shift_nxt[3:0];
                REG_SCAN_LIMIT:   scan_limit   <= shift_nxt[2:0];
                REG_SHUTDOWN:     normal_op    <= shift_nxt[0];
                REG_DISPLAY_TEST: display_test <= shift_nxt[0];
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule
